// File: rtl/pattern_detector.sv
// Serial pattern detector with per-bit don't-care mask, overlap/restart modes
// and a saturating match counter.
module pattern_detector #(
  parameter int unsigned LEN   = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in,
  input  logic             load,
  input  logic [LEN-1:0]   pattern,
  input  logic [LEN-1:0]   mask,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [4:0]       fill
);

  localparam int unsigned FILL_W = 5;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [LEN-1:0]    hist_q, hist_d;
  logic [LEN-1:0]    pat_q, pat_d;
  logic [LEN-1:0]    mask_q, mask_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [LEN-1:0]    hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              hit;

  // Next-state: load beats en; a hit is judged on the post-shift history.
  always_comb begin
    hist_d  = hist_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;

    hist_shift = {hist_q[LEN-2:0], in};
    fill_inc   = (fill_q >= FILL_MAX) ? FILL_MAX : fill_q + FILL_W'(1);
    hit        = en && !load && (fill_inc == FILL_MAX) &&
                 (((hist_shift ^ pat_q) & mask_q) == '0);

    if (load) begin
      pat_d  = pattern;
      mask_d = mask;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = hist_shift;
      fill_d = (hit && !overlap) ? '0 : fill_inc;
    end

    match_d = hit;

    // A clear coinciding with a match leaves exactly that match counted.
    if (clr_cnt) begin
      cnt_d = hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q  <= '0;
      pat_q   <= '0;
      mask_q  <= '1;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_pattern_detector.sv
// Directed, table-driven bench for pattern_detector (LEN=4, CNT_W=8).
module tb_pattern_detector;

  localparam int unsigned LEN   = 4;
  localparam int unsigned CNT_W = 8;

  typedef struct {
    logic           rst;
    logic           ld;
    logic           en;
    logic           din;
    logic           ov;
    logic           clr;
    logic [LEN-1:0] pat;
    logic [LEN-1:0] msk;
    logic           e_match;
    int             e_cnt;
    int             e_fill;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             din;
  logic             load;
  logic [LEN-1:0]   pattern;
  logic [LEN-1:0]   mask;
  logic             overlap;
  logic             clr_cnt;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic [4:0]       fill;

  int tests  = 0;
  int failed = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pattern_detector #(.LEN(LEN), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .in       (din),
    .load     (load),
    .pattern  (pattern),
    .mask     (mask),
    .overlap  (overlap),
    .clr_cnt  (clr_cnt),
    .match    (match),
    .match_cnt(match_cnt),
    .fill     (fill)
  );

  function automatic void v(logic rst, logic ld, logic e, logic d, logic ov, logic clr,
                            logic [LEN-1:0] p, logic [LEN-1:0] m,
                            logic em, int ec, int ef);
    vec_t t;
    t.rst = rst; t.ld = ld; t.en = e; t.din = d; t.ov = ov; t.clr = clr;
    t.pat = p; t.msk = m; t.e_match = em; t.e_cnt = ec; t.e_fill = ef;
    vecs.push_back(t);
  endfunction

  task automatic chk(string nm, int idx, int act, int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic apply(vec_t t, string nm, int idx);
    @(negedge clk);
    reset = t.rst; load = t.ld; en = t.en; din = t.din; overlap = t.ov;
    clr_cnt = t.clr; pattern = t.pat; mask = t.msk;
    @(posedge clk);
    #1;
    chk({nm, ".match"}, idx, int'(match), int'(t.e_match));
    chk({nm, ".cnt"},   idx, int'(match_cnt), t.e_cnt);
    chk({nm, ".fill"},  idx, int'(fill), t.e_fill);
  endtask

  initial begin
    vec_t t;
    int em, ec, ef;
    reset = 1'b1; load = 1'b0; en = 1'b0; din = 1'b0; overlap = 1'b1;
    clr_cnt = 1'b0; pattern = '0; mask = '0;

    //  rst ld en in ov clr pat      msk      match cnt fill
    v(1, 0, 0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
    // basic detection of 1011
    v(0, 1, 0, 0, 1, 0, 4'b1011, 4'b1111, 0, 0, 0);
    v(0, 0, 1, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 1);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 2);
    v(0, 0, 1, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 3);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 4);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 1, 1, 4);
    v(0, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 0, 1, 4);
    // 1111 with overlap: three pulses
    v(0, 1, 0, 0, 1, 1, 4'b1111, 4'b1111, 0, 0, 0);
    v(0, 0, 1, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 1);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 2);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 3);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 4);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 1, 1, 4);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 1, 2, 4);
    v(0, 0, 1, 0, 1, 0, 4'b0000, 4'b0000, 0, 2, 4);
    v(0, 0, 1, 0, 1, 0, 4'b0000, 4'b0000, 0, 2, 4);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 0, 2, 4);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 0, 2, 4);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 0, 2, 4);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 1, 3, 4);
    // 1111 without overlap: two pulses, fill restarts
    v(0, 1, 0, 0, 0, 1, 4'b1111, 4'b1111, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1);
    v(0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 2);
    v(0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 3);
    v(0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 4);
    v(0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 1, 1, 0);
    v(0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 1, 1);
    v(0, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 2);
    v(0, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 3);
    v(0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 1, 4);
    v(0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 1, 4);
    v(0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 1, 4);
    v(0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 1, 2, 0);
    // don't-care bits with en gaps
    v(0, 1, 0, 0, 1, 1, 4'b1001, 4'b1001, 0, 0, 0);
    v(0, 0, 1, 1, 1, 0, 4'b1111, 4'b1111, 0, 0, 1);
    v(0, 0, 0, 0, 1, 0, 4'b1111, 4'b1111, 0, 0, 1);
    v(0, 0, 1, 1, 1, 0, 4'b1111, 4'b1111, 0, 0, 2);
    v(0, 0, 0, 1, 1, 0, 4'b1111, 4'b1111, 0, 0, 2);
    v(0, 0, 0, 0, 1, 0, 4'b1111, 4'b1111, 0, 0, 2);
    v(0, 0, 1, 0, 1, 0, 4'b1111, 4'b1111, 0, 0, 3);
    v(0, 0, 0, 1, 1, 0, 4'b1111, 4'b1111, 0, 0, 3);
    v(0, 0, 1, 1, 1, 0, 4'b1111, 4'b1111, 1, 1, 4);
    v(0, 0, 0, 1, 1, 0, 4'b1111, 4'b1111, 0, 1, 4);
    // clear without match
    v(0, 0, 0, 0, 1, 1, 4'b0000, 4'b0000, 0, 0, 4);
    // load collides with en; new pattern 0000 takes over, live inputs ignored
    v(0, 1, 0, 0, 1, 1, 4'b1111, 4'b1111, 0, 0, 0);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 1);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 2);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 3);
    v(0, 1, 1, 1, 1, 0, 4'b0000, 4'b1111, 0, 0, 0);
    v(0, 0, 1, 0, 1, 0, 4'b1010, 4'b1111, 0, 0, 1);
    v(0, 0, 1, 0, 1, 0, 4'b1010, 4'b1111, 0, 0, 2);
    v(0, 0, 1, 0, 1, 0, 4'b1010, 4'b1111, 0, 0, 3);
    v(0, 0, 1, 0, 1, 0, 4'b1010, 4'b1111, 1, 1, 4);
    // overlap switched off with full history: next hit still counts, then restarts
    v(0, 1, 0, 0, 1, 1, 4'b0000, 4'b0000, 0, 0, 0);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 1);
    v(0, 0, 1, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 2);
    v(0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 3);
    v(0, 0, 1, 0, 1, 0, 4'b0000, 4'b0000, 1, 1, 4);
    v(0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 1, 2, 0);
    v(0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 2, 1);
    // reset mid-sequence wins over en; reset loads pattern 0000 / mask 1111
    v(0, 1, 0, 0, 1, 1, 4'b1111, 4'b1111, 0, 0, 0);
    v(0, 0, 1, 1, 1, 0, 4'b1111, 4'b1111, 0, 0, 1);
    v(0, 0, 1, 1, 1, 0, 4'b1111, 4'b1111, 0, 0, 2);
    v(0, 0, 1, 1, 1, 0, 4'b1111, 4'b1111, 0, 0, 3);
    v(1, 1, 1, 1, 1, 1, 4'b1111, 4'b1111, 0, 0, 0);
    v(0, 0, 1, 1, 1, 0, 4'b1111, 4'b1111, 0, 0, 1);
    v(0, 0, 1, 0, 1, 0, 4'b1111, 4'b0000, 0, 0, 2);
    v(0, 0, 1, 0, 1, 0, 4'b1111, 4'b0000, 0, 0, 3);
    v(0, 0, 1, 0, 1, 0, 4'b1111, 4'b0000, 0, 0, 4);
    v(0, 0, 1, 0, 1, 0, 4'b1111, 4'b0000, 1, 1, 4);

    foreach (vecs[i]) apply(vecs[i], "tbl", i);

    // Saturation: mask 0000 hits every en cycle once four bits are in.
    t = '{rst:0, ld:1, en:0, din:0, ov:1, clr:1, pat:4'b0000, msk:4'b0000,
          e_match:0, e_cnt:0, e_fill:0};
    apply(t, "sat_load", 0);
    for (int i = 0; i < 300; i++) begin
      em = (i >= 3) ? 1 : 0;
      ec = (i >= 3) ? ((i - 2 > 255) ? 255 : i - 2) : 0;
      ef = (i + 1 > 4) ? 4 : i + 1;
      t = '{rst:0, ld:0, en:1, din:i[0], ov:1, clr:0, pat:4'b1111, msk:4'b1111,
            e_match:em[0], e_cnt:ec, e_fill:ef};
      apply(t, "sat", i);
    end
    t = '{rst:0, ld:0, en:0, din:0, ov:1, clr:0, pat:4'b0000, msk:4'b0000,
          e_match:0, e_cnt:255, e_fill:4};
    apply(t, "sat_hold", 0);
    t = '{rst:0, ld:0, en:1, din:1, ov:1, clr:1, pat:4'b0000, msk:4'b0000,
          e_match:1, e_cnt:1, e_fill:4};
    apply(t, "clr_with_match", 0);
    t = '{rst:0, ld:0, en:1, din:0, ov:1, clr:0, pat:4'b0000, msk:4'b0000,
          e_match:1, e_cnt:2, e_fill:4};
    apply(t, "after_clr", 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
